bp_history_ctrl: RTL and testbench

BP_HISTORY_CTRL -- requirements
Module: bp_history_ctrl

---
 rtl/bp_history_ctrl.sv | 157 +++++++++++++++
 tb/tb_bp_history_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_history_ctrl.sv
// Speculative global-history register backed by an in-order queue of in-flight B branches.
// Optional feature: define BP_TRAIN_ALWAYS_EN to also train on correctly predicted resolves.
module bp_history_ctrl #(
    parameter int QDEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_predValid,
    output logic        o_predReady,
    input  logic [2:0]  i_passBNum_3,
    input  logic        i_predictGotJ,
    input  logic        i_resolveValid,
    output logic        o_resolveReady,
    input  logic        i_resolveTaken,
    input  logic [31:0] i_correctPC_32,
    output logic [19:0] o_globalHistoryRegister_20,
    output logic [7:0]  o_pendingB_8,
    output logic        o_flush,
    output logic [31:0] o_correctPC_32,
    output logic        o_trainValid,
    output logic [19:0] o_trainHistory_20,
    output logic        o_trainTaken,
    output logic [1:0]  o_trainSlot_2,
    input  logic        i_trainReady
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH    = (PW+1)'(QDEPTH);
    localparam logic [PW:0] MIN_FREE = (PW+1)'(4);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state;
    state_t        stateNext;
    logic [19:0]   ghr;
    logic [19:0]   ghrNext;
    logic [PW:0]   count;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;

    logic [19:0]   qSnap [QDEPTH];
    logic          qDir  [QDEPTH];
    logic [1:0]    qSlot [QDEPTH];

    logic [19:0]   headSnap;
    logic          headDir;
    logic [1:0]    headSlot;
    logic [2:0]    passN;
    logic [PW:0]   pushN;
    logic          predFire;
    logic          pushFire;
    logic          resolveFire;
    logic          mispredict;
    logic          flushFire;
    logic          popFire;
    logic          trainLoad;

    assign passN    = i_passBNum_3;
    assign headSnap = qSnap[rdPtr];
    assign headDir  = qDir[rdPtr];
    assign headSlot = qSlot[rdPtr];

    assign o_predReady    = (state == RUN) && ((DEPTH - count) >= MIN_FREE);
    assign o_resolveReady = (state == RUN) && (count != '0) && !(o_trainValid && !i_trainReady);

    assign predFire    = i_predValid && o_predReady;
    assign resolveFire = i_resolveValid && o_resolveReady;
    assign mispredict  = |i_correctPC_32;
    assign flushFire   = resolveFire && mispredict;
    assign popFire     = resolveFire && !mispredict;
    // A flush wins over a same-cycle group: the group was predicted down the wrong path.
    assign pushFire    = predFire && (passN <= 3'd4) && !flushFire;
    assign pushN       = pushFire ? (PW+1)'(passN) : '0;

`ifdef BP_TRAIN_ALWAYS_EN
    assign trainLoad = resolveFire;
`else
    assign trainLoad = flushFire;
`endif

    always_comb begin
        ghrNext = ghr;
        if (flushFire)
            ghrNext = {headSnap[18:0], i_resolveTaken};
        else if (pushFire)
            ghrNext = (ghr << passN) | {19'd0, i_predictGotJ && (passN != 3'd0)};
    end

    always_comb begin
        stateNext = state;
        o_flush   = 1'b0;
        case (state)
            RUN:   if (flushFire) stateNext = FLUSH;
            FLUSH: begin
                o_flush   = 1'b1;
                stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= RUN;
            ghr               <= '0;
            count             <= '0;
            rdPtr             <= '0;
            wrPtr             <= '0;
            o_correctPC_32    <= '0;
            o_trainValid      <= 1'b0;
            o_trainHistory_20 <= '0;
            o_trainTaken      <= 1'b0;
            o_trainSlot_2     <= '0;
        end else begin
            state <= stateNext;
            ghr   <= ghrNext;
            if (flushFire) begin
                count          <= '0;
                rdPtr          <= '0;
                wrPtr          <= '0;
                o_correctPC_32 <= i_correctPC_32;
            end else begin
                count <= count + pushN - (PW+1)'(popFire);
                rdPtr <= rdPtr + PW'(popFire);
                wrPtr <= wrPtr + PW'(pushN);
            end
            if (trainLoad) begin
                o_trainValid      <= 1'b1;
                o_trainHistory_20 <= headSnap;
                o_trainTaken      <= i_resolveTaken;
                o_trainSlot_2     <= headSlot;
            end else if (i_trainReady) begin
                o_trainValid <= 1'b0;
            end
        end
    end

    // Entry k of a group sees the history with the k earlier not-taken bits already shifted in.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pushFire && (k < int'(passN))) begin
                qSnap[wrPtr + PW'(k)] <= ghr << k;
                qDir[wrPtr + PW'(k)]  <= (k == int'(passN) - 1) && i_predictGotJ;
                qSlot[wrPtr + PW'(k)] <= 2'(k);
            end
        end
    end

    // A resolve reported as correct must agree with the direction stored at push time.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && popFire)
            assert (i_resolveTaken == headDir);
    end

    assign o_globalHistoryRegister_20 = ghr;
    assign o_pendingB_8               = 8'(count);

endmodule

// File: tb/tb_bp_history_ctrl.sv
// Self-checking bench for bp_history_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_bp_history_ctrl;

    localparam int QDEPTH = 8;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_predValid;
    logic        o_predReady;
    logic [2:0]  i_passBNum_3;
    logic        i_predictGotJ;
    logic        i_resolveValid;
    logic        o_resolveReady;
    logic        i_resolveTaken;
    logic [31:0] i_correctPC_32;
    logic [19:0] o_globalHistoryRegister_20;
    logic [7:0]  o_pendingB_8;
    logic        o_flush;
    logic [31:0] o_correctPC_32;
    logic        o_trainValid;
    logic [19:0] o_trainHistory_20;
    logic        o_trainTaken;
    logic [1:0]  o_trainSlot_2;
    logic        i_trainReady;

    bp_history_ctrl #(.QDEPTH(QDEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_predValid(i_predValid), .o_predReady(o_predReady),
        .i_passBNum_3(i_passBNum_3), .i_predictGotJ(i_predictGotJ),
        .i_resolveValid(i_resolveValid), .o_resolveReady(o_resolveReady),
        .i_resolveTaken(i_resolveTaken), .i_correctPC_32(i_correctPC_32),
        .o_globalHistoryRegister_20(o_globalHistoryRegister_20), .o_pendingB_8(o_pendingB_8),
        .o_flush(o_flush), .o_correctPC_32(o_correctPC_32),
        .o_trainValid(o_trainValid), .o_trainHistory_20(o_trainHistory_20),
        .o_trainTaken(o_trainTaken), .o_trainSlot_2(o_trainSlot_2),
        .i_trainReady(i_trainReady)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic [19:0] snap;
        logic        dir;
        logic [1:0]  slot;
    } ent_t;

    ent_t        mq[$];
    logic [19:0] mGhr;
    logic        mFlush;
    logic [31:0] mPc;
    logic        mTv;
    logic [19:0] mTh;
    logic        mTt;
    logic [1:0]  mTs;

    function automatic bit mPredReady();
        return !mFlush && ((QDEPTH - mq.size()) >= 4);
    endfunction

    function automatic bit mResReady();
        return !mFlush && (mq.size() > 0) && !(mTv && !i_trainReady);
    endfunction

    task automatic modelReset();
        mq.delete();
        mGhr = '0; mFlush = 1'b0; mPc = '0;
        mTv = 1'b0; mTh = '0; mTt = 1'b0; mTs = '0;
    endtask

    task automatic drive(input logic pv, input logic [2:0] n, input logic j,
                         input logic rv, input logic rt, input logic [31:0] pc, input logic tr);
        i_predValid = pv; i_passBNum_3 = n; i_predictGotJ = j;
        i_resolveValid = rv; i_resolveTaken = rt; i_correctPC_32 = pc; i_trainReady = tr;
    endtask

    // One clock: the model takes the same edge from the branch-level rules, then returns 1 after it.
    task automatic tick();
        bit pf, rf, misp, nextFlush;
        ent_t h, e;
        pf = i_predValid && mPredReady();
        rf = i_resolveValid && mResReady();
        misp = (i_correctPC_32 != 32'd0);
        @(posedge i_clk);
        nextFlush = 1'b0;
        if (mTv && i_trainReady) mTv = 1'b0;
        if (rf) begin
            h = mq[0];
            if (misp) begin
                mq.delete();
                mGhr = {h.snap[18:0], i_resolveTaken};
                mPc = i_correctPC_32;
                mTv = 1'b1; mTh = h.snap; mTt = i_resolveTaken; mTs = h.slot;
                nextFlush = 1'b1;
            end else begin
                void'(mq.pop_front());
`ifdef BP_TRAIN_ALWAYS_EN
                mTv = 1'b1; mTh = h.snap; mTt = i_resolveTaken; mTs = h.slot;
`endif
            end
        end
        if (pf && !(rf && misp) && (i_passBNum_3 <= 3'd4)) begin
            for (int k = 0; k < int'(i_passBNum_3); k++) begin
                e.snap = mGhr;
                e.dir  = (k == int'(i_passBNum_3) - 1) && i_predictGotJ;
                e.slot = 2'(k);
                mq.push_back(e);
                mGhr = {mGhr[18:0], e.dir};
            end
        end
        mFlush = nextFlush;
        #1;
    endtask

    task automatic applyReset();
        drive(0, 0, 0, 0, 0, 0, 1);
        i_rst_n = 1'b0;
        #1;
        modelReset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        i_rst_n = 1'b0;
        #12;
        modelReset();
        vecs++;
        if ({o_globalHistoryRegister_20, o_pendingB_8, o_flush, o_correctPC_32,
             o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: ghr=%h pend=%0d flush=%b pc=%h tv=%b th=%h tt=%b ts=%0d, all must be 0",
                     o_globalHistoryRegister_20, o_pendingB_8, o_flush, o_correctPC_32,
                     o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2);
        end
        vecs++;
        if (o_resolveReady !== 1'b0) begin
            errs++; $display("FAIL reset_resolveReady: got %b want 0", o_resolveReady);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_group_push();
        applyReset();
        drive(1, 3, 1, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        vecs++;
        if (o_globalHistoryRegister_20 !== 20'h00001) begin
            errs++; $display("FAIL push3_ghr: got %h want 00001", o_globalHistoryRegister_20);
        end
        vecs++;
        if (o_pendingB_8 !== 8'd3) begin
            errs++; $display("FAIL push3_pending: got %0d want 3", o_pendingB_8);
        end
        drive(0, 0, 0, 1, 0, 0, 1); tick(); tick();
        drive(0, 0, 0, 1, 0, 32'h4, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        vecs++;
        if ({o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2} !== {1'b1, 20'h0, 1'b0, 2'd2}) begin
            errs++;
            $display("FAIL push3_slot2_snapshot: got tv=%b th=%h tt=%b ts=%0d want 1 00000 0 2",
                     o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2);
        end
    endtask

    task automatic test_pred_backpressure();
        applyReset();
        drive(1, 4, 0, 0, 0, 0, 1); tick();
        drive(1, 1, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        vecs++;
        if ({o_predReady, o_pendingB_8} !== {1'b0, 8'd5}) begin
            errs++; $display("FAIL fill5_predReady: got ready=%b pend=%0d want 0 5", o_predReady, o_pendingB_8);
        end
        drive(0, 0, 0, 1, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        vecs++;
        if ({o_predReady, o_pendingB_8} !== {1'b1, 8'd4}) begin
            errs++; $display("FAIL after_pop_predReady: got ready=%b pend=%0d want 1 4", o_predReady, o_pendingB_8);
        end
    endtask

    task automatic test_mispredict();
        applyReset();
        repeat (4) begin drive(1, 1, 1, 0, 0, 0, 1); tick(); end
        repeat (3) begin drive(0, 0, 0, 1, 1, 0, 1); tick(); end
        drive(0, 0, 0, 0, 0, 0, 1);
        vecs++;
        if ({o_globalHistoryRegister_20, o_pendingB_8} !== {20'h0000F, 8'd1}) begin
            errs++; $display("FAIL mp_setup: got ghr=%h pend=%0d want 0000F 1", o_globalHistoryRegister_20, o_pendingB_8);
        end
        drive(0, 0, 0, 1, 0, 32'h80001000, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        vecs++;
        if ({o_flush, o_globalHistoryRegister_20, o_pendingB_8, o_correctPC_32} !==
            {1'b1, 20'h0000E, 8'd0, 32'h80001000}) begin
            errs++;
            $display("FAIL mp_state: got flush=%b ghr=%h pend=%0d pc=%h want 1 0000E 0 80001000",
                     o_flush, o_globalHistoryRegister_20, o_pendingB_8, o_correctPC_32);
        end
        vecs++;
        if ({o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2} !== {1'b1, 20'h00007, 1'b0, 2'd0}) begin
            errs++;
            $display("FAIL mp_train: got tv=%b th=%h tt=%b ts=%0d want 1 00007 0 0",
                     o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2);
        end
        #1;
        vecs++;
        if ({o_predReady, o_resolveReady} !== 2'b00) begin
            errs++; $display("FAIL flush_readies: got pred=%b res=%b want 0 0", o_predReady, o_resolveReady);
        end
        tick();
        vecs++;
        if ({o_flush, o_correctPC_32} !== {1'b0, 32'h80001000}) begin
            errs++; $display("FAIL flush_one_cycle: got flush=%b pc=%h want 0 80001000", o_flush, o_correctPC_32);
        end
    endtask

    task automatic test_train_stall();
        applyReset();
        drive(1, 2, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 1, 32'h100, 0); tick();
        drive(1, 2, 1, 0, 0, 0, 0); tick();
        vecs++;
        if (o_pendingB_8 !== 8'd0) begin
            errs++; $display("FAIL push_in_flush: got pend=%0d want 0", o_pendingB_8);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        vecs++;
        if (o_resolveReady !== 1'b0) begin
            errs++; $display("FAIL stall_resolveReady: got %b want 0", o_resolveReady);
        end
        tick(); tick();
        vecs++;
        if ({o_pendingB_8, o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2} !==
            {8'd2, 1'b1, 20'h0, 1'b1, 2'd0}) begin
            errs++;
            $display("FAIL stall_payload: got pend=%0d tv=%b th=%h tt=%b ts=%0d want 2 1 00000 1 0",
                     o_pendingB_8, o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2);
        end
        i_trainReady = 1'b1; #1;
        vecs++;
        if (o_resolveReady !== 1'b1) begin
            errs++; $display("FAIL release_resolveReady: got %b want 1", o_resolveReady);
        end
        tick();
        vecs++;
        if (o_pendingB_8 !== 8'd1) begin
            errs++; $display("FAIL release_pop: got pend=%0d want 1", o_pendingB_8);
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        drive(1, 3, 0, 0, 0, 0, 1); tick();
        drive(1, 2, 0, 1, 0, 0, 1); tick();
        vecs++;
        if ({o_pendingB_8, o_globalHistoryRegister_20} !== {8'd4, 20'h0}) begin
            errs++; $display("FAIL push_and_pop: got pend=%0d ghr=%h want 4 00000", o_pendingB_8, o_globalHistoryRegister_20);
        end
    endtask

    task automatic test_reset_mid_flush();
        applyReset();
        drive(1, 1, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 32'h44, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        vecs++;
        if ({o_flush, o_trainValid} !== 2'b11) begin
            errs++; $display("FAIL pre_reset_flush: got flush=%b tv=%b want 1 1", o_flush, o_trainValid);
        end
        #2 i_rst_n = 1'b0;
        #1;
        modelReset();
        vecs++;
        if ({o_globalHistoryRegister_20, o_pendingB_8, o_flush, o_correctPC_32,
             o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2} !== '0) begin
            errs++;
            $display("FAIL async_reset: ghr=%h pend=%0d flush=%b pc=%h tv=%b th=%h tt=%b ts=%0d, all must be 0",
                     o_globalHistoryRegister_20, o_pendingB_8, o_flush, o_correctPC_32,
                     o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(1, 3, 1, 0, 0, 0, 1); tick();
        drive(1, 7, 1, 0, 0, 0, 1); tick();
        vecs++;
        if ({o_globalHistoryRegister_20, o_pendingB_8} !== {20'h00001, 8'd3}) begin
            errs++; $display("FAIL n7_ignored: got ghr=%h pend=%0d want 00001 3", o_globalHistoryRegister_20, o_pendingB_8);
        end
    endtask

    task automatic test_random();
        logic        pv, j, rv, rt, tr, misp;
        logic [2:0]  n;
        logic [31:0] pc;
        int          r;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom % 4) != 0;
            r = $urandom_range(0, 9);
            n = (r < 8) ? 3'(r % 5) : 3'(5 + ($urandom % 3));
            j = 1'($urandom);
            rv = ($urandom % 3) != 0;
            misp = ($urandom % 8) == 0;
            rt = (!misp && mq.size() > 0) ? mq[0].dir : 1'($urandom);
            pc = misp ? ($urandom | 32'h1) : 32'h0;
            tr = ($urandom % 4) != 0;
            drive(pv, n, j, rv, rt, pc, tr);
            #1;
            vecs++;
            if ({o_predReady, o_resolveReady} !== {mPredReady(), mResReady()}) begin
                errs++; $display("FAIL rnd_ready[%0d]: got pred=%b res=%b want %b %b",
                                 i, o_predReady, o_resolveReady, mPredReady(), mResReady());
            end
            tick();
            vecs++;
            if ({o_globalHistoryRegister_20, o_pendingB_8, o_flush, o_correctPC_32} !==
                {mGhr, 8'(mq.size()), mFlush, mPc}) begin
                errs++; $display("FAIL rnd_state[%0d]: got ghr=%h pend=%0d flush=%b pc=%h want %h %0d %b %h",
                                 i, o_globalHistoryRegister_20, o_pendingB_8, o_flush, o_correctPC_32,
                                 mGhr, mq.size(), mFlush, mPc);
            end
            vecs++;
            if ({o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2} !== {mTv, mTh, mTt, mTs}) begin
                errs++; $display("FAIL rnd_train[%0d]: got tv=%b th=%h tt=%b ts=%0d want %b %h %b %0d",
                                 i, o_trainValid, o_trainHistory_20, o_trainTaken, o_trainSlot_2, mTv, mTh, mTt, mTs);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        modelReset();
        test_reset();
        test_group_push();
        test_pred_backpressure();
        test_mispredict();
        test_train_stall();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
